// File: rtl/sa_pkg.sv
// Shared systolic-array types and constants for the output-buffer unloader.
// Defining OB_CLEAR_EN adds the OB_CLR state to ob_unld_state_e.
package sa_pkg;

  localparam int SA_WIDTH  = 8;
  localparam int SA_COL    = 4;
  localparam int SA_O_SIZE = 256;

  // SRAM strobes are active low
  localparam logic MEM_EN = 1'b0;
  localparam logic MEM_WR = 1'b0;

  typedef logic [SA_COL-1:0][SA_WIDTH-1:0] ob_row_t;

  typedef enum logic [2:0] {
    OB_IDLE = 3'd0,
    OB_RD   = 3'd1,
    OB_CAP  = 3'd2,
    OB_SEND = 3'd3,
`ifdef OB_CLEAR_EN
    OB_CLR  = 3'd4,
`endif
    OB_FIN  = 3'd5
  } ob_unld_state_e;

endpackage

// File: rtl/ob_unloader.sv
// Drains rows from the output-buffer SRAM and serializes them onto a word stream.
// Defining OB_CLEAR_EN writes each row back to zero after it has been sent.
//
// state | meaning
// IDLE  | waiting for start_i; base/num latched here
// RD    | read issued for row base+row_cnt
// CAP   | SRAM read data captured into row_q
// SEND  | streaming elements of row_q, element 0 first
// CLR   | (OB_CLEAR_EN) zero the row just sent
// FIN   | one-cycle done pulse
module ob_unloader
  import sa_pkg::*;
#(
  parameter int WIDTH  = SA_WIDTH,
  parameter int COL    = SA_COL,
  parameter int O_SIZE = SA_O_SIZE,
  localparam int AW    = $clog2(O_SIZE)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AW-1:0]        base_addr_i,
  input  logic [AW:0]          num_rows_i,
  output logic                 ob_mem_cenb_o,
  output logic                 ob_mem_wenb_o,
  output logic [AW-1:0]        ob_mem_addr_o,
  output logic [COL*WIDTH-1:0] ob_mem_data_o,
  input  logic [COL*WIDTH-1:0] ob_mem_data_i,
  output logic                 m_valid_o,
  output logic [WIDTH-1:0]     m_data_o,
  output logic                 m_last_o,
  input  logic                 m_ready_i,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int NW = AW + 1;
  localparam int EW = (COL > 1) ? $clog2(COL) : 1;
  localparam logic [NW-1:0] ONE_ROW  = NW'(1);
  localparam logic [EW-1:0] ONE_ELEM = EW'(1);
  localparam logic [EW-1:0] LAST_ELEM = EW'(COL - 1);

  typedef logic [COL-1:0][WIDTH-1:0] row_t;

  ob_unld_state_e  state_q, state_d;
  logic [AW-1:0]   base_q, base_d;
  logic [NW-1:0]   num_q, num_d;
  logic [NW-1:0]   row_cnt_q, row_cnt_d;
  row_t            row_q, row_d;
  logic [EW-1:0]   elem_q, elem_d;

  logic            last_row;
  logic            last_elem;
  logic [NW-1:0]   addr_sum;
  logic [AW-1:0]   row_addr;
  logic            rd_acc;
  logic            wr_acc;

  assign last_row  = (row_cnt_q == (num_q - ONE_ROW));
  assign last_elem = (elem_q == LAST_ELEM);

  // base and row_cnt are both below O_SIZE, so one conditional subtract wraps
  assign addr_sum = {1'b0, base_q} + row_cnt_q;
  assign row_addr = (addr_sum >= NW'(O_SIZE)) ? AW'(addr_sum - NW'(O_SIZE))
                                              : addr_sum[AW-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= OB_IDLE;
      base_q    <= '0;
      num_q     <= '0;
      row_cnt_q <= '0;
      row_q     <= '0;
      elem_q    <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      num_q     <= num_d;
      row_cnt_q <= row_cnt_d;
      row_q     <= row_d;
      elem_q    <= elem_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    num_d     = num_q;
    row_cnt_d = row_cnt_q;
    row_d     = row_q;
    elem_d    = elem_q;
    unique case (state_q)
      OB_IDLE: begin
        if (start_i) begin
          base_d    = base_addr_i;
          num_d     = num_rows_i;
          row_cnt_d = '0;
          state_d   = (num_rows_i == '0) ? OB_FIN : OB_RD;
        end
      end
      OB_RD: state_d = OB_CAP;
      OB_CAP: begin
        row_d   = ob_mem_data_i;
        elem_d  = '0;
        state_d = OB_SEND;
      end
      OB_SEND: begin
        if (m_ready_i) begin
          if (!last_elem) begin
            elem_d = elem_q + ONE_ELEM;
          end else begin
`ifdef OB_CLEAR_EN
            state_d = OB_CLR;
`else
            row_cnt_d = row_cnt_q + ONE_ROW;
            state_d   = last_row ? OB_FIN : OB_RD;
`endif
          end
        end
      end
`ifdef OB_CLEAR_EN
      // row_cnt advances only here so the clear reuses the read address
      OB_CLR: begin
        row_cnt_d = row_cnt_q + ONE_ROW;
        state_d   = last_row ? OB_FIN : OB_RD;
      end
`endif
      OB_FIN:  state_d = OB_IDLE;
      default: state_d = OB_IDLE;
    endcase
  end

  // Accesses are suppressed while rst_i is high, even if the old state would access
  assign rd_acc = (state_q == OB_RD) && !rst_i;
`ifdef OB_CLEAR_EN
  assign wr_acc = (state_q == OB_CLR) && !rst_i;
`else
  assign wr_acc = 1'b0;
`endif

  assign ob_mem_cenb_o = (rd_acc || wr_acc) ? MEM_EN : ~MEM_EN;
  assign ob_mem_wenb_o = wr_acc ? MEM_WR : ~MEM_WR;
  assign ob_mem_addr_o = (rd_acc || wr_acc) ? row_addr : '0;
  assign ob_mem_data_o = '0;

  assign m_valid_o = (state_q == OB_SEND);
  assign m_data_o  = m_valid_o ? row_q[elem_q] : '0;
  assign m_last_o  = m_valid_o && last_elem && last_row;
  assign busy_o    = (state_q != OB_IDLE);
  assign done_o    = (state_q == OB_FIN);

endmodule

// File: tb/tb_ob_unloader.sv
// Self-checking bench for ob_unloader: table-driven drains plus reset/clear sequences.
// Build with OB_CLEAR_EN defined to exercise the row-clear feature.
module tb_ob_unloader;

  localparam int WIDTH  = 8;
  localparam int COL    = 4;
  localparam int O_SIZE = 256;
  localparam int AW     = 8;
  localparam int NW     = AW + 1;
  localparam int DW     = COL * WIDTH;
`ifdef OB_CLEAR_EN
  localparam int CLR_CYC = 1;
`else
  localparam int CLR_CYC = 0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [NW-1:0] num_rows_i = '0;
  logic          ob_mem_cenb_o;
  logic          ob_mem_wenb_o;
  logic [AW-1:0] ob_mem_addr_o;
  logic [DW-1:0] ob_mem_data_o;
  logic [DW-1:0] ob_mem_data_i = '0;
  logic          m_valid_o;
  logic [WIDTH-1:0] m_data_o;
  logic          m_last_o;
  logic          m_ready_i = 1'b0;
  logic          busy_o;
  logic          done_o;

  always #5 clk_i = ~clk_i;

  ob_unloader #(.WIDTH(WIDTH), .COL(COL), .O_SIZE(O_SIZE)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .base_addr_i   (base_addr_i),
    .num_rows_i    (num_rows_i),
    .ob_mem_cenb_o (ob_mem_cenb_o),
    .ob_mem_wenb_o (ob_mem_wenb_o),
    .ob_mem_addr_o (ob_mem_addr_o),
    .ob_mem_data_o (ob_mem_data_o),
    .ob_mem_data_i (ob_mem_data_i),
    .m_valid_o     (m_valid_o),
    .m_data_o      (m_data_o),
    .m_last_o      (m_last_o),
    .m_ready_i     (m_ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  // SRAM model (1-cycle read latency) plus an access log
  typedef struct {logic wr; logic [AW-1:0] addr; logic [DW-1:0] data;} acc_t;
  acc_t acc_q[$];
  logic [DW-1:0] sram    [O_SIZE];
  logic [DW-1:0] ref_mem [O_SIZE];

  always @(posedge clk_i) begin
    if (ob_mem_cenb_o == 1'b0) begin
      acc_q.push_back('{wr: !ob_mem_wenb_o, addr: ob_mem_addr_o, data: ob_mem_data_o});
      if (!ob_mem_wenb_o) sram[ob_mem_addr_o] <= ob_mem_data_o;
      else                ob_mem_data_i <= sram[ob_mem_addr_o];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " cenb"},   ob_mem_cenb_o, 1);
    chk({tag, " wenb"},   ob_mem_wenb_o, 1);
    chk({tag, " addr"},   ob_mem_addr_o, 0);
    chk({tag, " wdata"},  ob_mem_data_o, 0);
    chk({tag, " valid"},  m_valid_o, 0);
    chk({tag, " m_data"}, m_data_o, 0);
    chk({tag, " last"},   m_last_o, 0);
    chk({tag, " busy"},   busy_o, 0);
    chk({tag, " done"},   done_o, 0);
  endtask

  // Reference: the words a drain must produce, straight from the row contents
  typedef struct {logic [WIDTH-1:0] data; logic last;} word_t;
  word_t exp_q[$];

  function automatic void build_expect(input int base, input int num);
    exp_q.delete();
    for (int r = 0; r < num; r++) begin
      logic [DW-1:0] row;
      row = ref_mem[(base + r) % O_SIZE];
      for (int e = 0; e < COL; e++)
        exp_q.push_back('{data: row[e*WIDTH +: WIDTH], last: (r == num - 1) && (e == COL - 1)});
    end
  endfunction

  function automatic logic ready_val(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 2) == 0;
      2:       return $urandom_range(0, 3) != 0;
      default: return (c >= 6 && c < 11) ? 1'b0 : ((c % 2) == 0);
    endcase
  endfunction

  task automatic run_drain(input string tag, input int base, input int num,
                           input int mode, input int exp_busy);
    int c, busy_cyc, words;
    bit fin, prev_stall;
    logic [WIDTH-1:0] prev_data;
    word_t w;
    c = 0; busy_cyc = 0; words = 0; fin = 0; prev_stall = 0; prev_data = '0;
    build_expect(base, num);
    acc_q.delete();
    @(negedge clk_i);
    start_i = 1'b1;
    base_addr_i = AW'(base);
    num_rows_i  = NW'(num);
    @(negedge clk_i);
    start_i = 1'b0;
    base_addr_i = AW'($urandom);
    num_rows_i  = NW'($urandom_range(1, O_SIZE));
    while (!fin && c < 4000) begin
      m_ready_i = ready_val(mode, c);
      start_i = (c == 3);
      if (busy_o) busy_cyc++;
      if (prev_stall) begin
        chk({tag, " stall valid"}, m_valid_o, 1);
        chk({tag, " stall data"},  m_data_o, prev_data);
      end
      if (m_last_o && !m_valid_o) chk({tag, " last w/o valid"}, 1, 0);
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) begin
          chk({tag, " extra word"}, 1, 0);
        end else begin
          w = exp_q.pop_front();
          chk({tag, " data"}, m_data_o, w.data);
          chk({tag, " last"}, m_last_o, w.last);
        end
        words++;
      end
      prev_stall = m_valid_o && !m_ready_i;
      prev_data  = m_data_o;
      if (done_o) fin = 1;
      c++;
      if (!fin) @(negedge clk_i);
    end
    start_i = 1'b0;
    chk({tag, " done seen"}, fin, 1);
    chk({tag, " word count"}, words, num * COL);
    chk({tag, " words left"}, exp_q.size(), 0);
    if (exp_busy >= 0) chk({tag, " busy cycles"}, busy_cyc, exp_busy);
    chk({tag, " access count"}, acc_q.size(), num * (1 + CLR_CYC));
    for (int r = 0; r < num && acc_q.size() > 0; r++) begin
      acc_t a;
      a = acc_q.pop_front();
      chk({tag, " rd kind"}, a.wr, 0);
      chk({tag, " rd addr"}, a.addr, (base + r) % O_SIZE);
`ifdef OB_CLEAR_EN
      if (acc_q.size() > 0) begin
        a = acc_q.pop_front();
        chk({tag, " clr kind"}, a.wr, 1);
        chk({tag, " clr addr"}, a.addr, (base + r) % O_SIZE);
        chk({tag, " clr data"}, a.data, 0);
      end
      ref_mem[(base + r) % O_SIZE] = '0;
      chk({tag, " row zeroed"}, sram[(base + r) % O_SIZE], 0);
`endif
    end
    @(negedge clk_i);
    chk({tag, " done pulse width"}, done_o, 0);
    chk({tag, " idle after"}, busy_o, 0);
    chk({tag, " no idle access"}, ob_mem_cenb_o, 1);
  endtask

  typedef struct {int base; int num; int mode; int exp_busy;} vec_t;
  vec_t vec[7];

  initial begin
    int hs;
    for (int i = 0; i < O_SIZE; i++) begin
      sram[i] = DW'($urandom);
      ref_mem[i] = sram[i];
    end
    sram[0] = 32'h04030201;
    ref_mem[0] = 32'h04030201;

    // T1, T2, T4, T3, toggle, random, full-depth wrap
    vec[0] = '{0,          1,      0, 1 * (2 + COL + CLR_CYC) + 1};
    vec[1] = '{O_SIZE - 1, 2,      0, 2 * (2 + COL + CLR_CYC) + 1};
    vec[2] = '{37,         0,      0, 1};
    vec[3] = '{100,        2,      3, -1};
    vec[4] = '{5,          3,      1, -1};
    vec[5] = '{200,        4,      2, -1};
    vec[6] = '{17,         O_SIZE, 0, O_SIZE * (2 + COL + CLR_CYC) + 1};

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_idle("reset");
    rst_i = 1'b0;
    @(negedge clk_i);
    check_idle("post reset");

    for (int i = 0; i < 7; i++)
      run_drain($sformatf("vec%0d", i), vec[i].base, vec[i].num, vec[i].mode, vec[i].exp_busy);

    for (int i = 0; i < 6; i++)
      run_drain($sformatf("rnd%0d", i), $urandom_range(0, O_SIZE - 1),
                $urandom_range(1, 20), 2, -1);

    // T5: reset during SEND of row 1, then a clean re-drain
    @(negedge clk_i);
    start_i = 1'b1; base_addr_i = AW'(50); num_rows_i = NW'(3);
    @(negedge clk_i);
    start_i = 1'b0; m_ready_i = 1'b1;
    hs = 0;
    for (int c = 0; c < 100; c++) begin
      if (m_valid_o && m_ready_i) hs++;
      if (hs == COL + 1) break;
      @(negedge clk_i);
    end
    chk("T5 reached row1", hs, COL + 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check_idle("T5 after reset");
`ifdef OB_CLEAR_EN
    ref_mem[50] = '0;
`endif
    @(negedge clk_i);
    check_idle("T5 stays idle");
    run_drain("T5 redrain", 50, 3, 0, 3 * (2 + COL + CLR_CYC) + 1);

`ifdef OB_CLEAR_EN
    // T6: clear pass then a re-drain of the same rows must stream zeros
    run_drain("T6 clear", 120, 3, 0, 3 * (3 + COL) + 1);
    build_expect(120, 3);
    for (int i = 0; i < 3 * COL; i++) chk("T6 ref zero", exp_q[i].data, 0);
    run_drain("T6 redrain", 120, 3, 1, -1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
